sht21_uart_fmt: RTL and testbench



---
 rtl/sht21_uart_fmt.sv | 151 +++++++++++++++
 tb/tb_sht21_uart_fmt.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sht21_uart_fmt.sv
// Formats one captured SHT21 temperature/humidity pair as "T=XXXX H=XXXX\r\n"
// and hands it byte by byte to the UART transmitter via its tx_req/tx_en handshake.
module sht21_uart_fmt #(
    parameter int REQ_HOLD    = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] temp_raw,
    input  logic [15:0] humi_raw,
    input  logic        data_valid,
    input  logic        tx_en,
    output logic [7:0]  tx_byte,
    output logic        tx_req,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [7:0]  drop_cnt
);
    localparam int CNT_MAX = (REQ_HOLD > ACK_TIMEOUT) ? REQ_HOLD : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FALL, S_DRAIN, S_DONE, S_ABORT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      temp_q, temp_d, humi_q, humi_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       drop_q, drop_d;
    logic             load;
    logic [31:0]      words_d;
    logic [7:0]       nib_chr [8];

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // The capture-cycle words feed the encoder so byte 0 can be loaded on the capture edge.
    assign temp_d  = (state_q == S_IDLE && data_valid) ? temp_raw : temp_q;
    assign humi_d  = (state_q == S_IDLE && data_valid) ? humi_raw : humi_q;
    assign words_d = {temp_d, humi_d};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            assign nib_chr[gi] = hex_char(words_d[31-4*gi -: 4]);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    load    = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_W'(REQ_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FALL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FALL: begin
                if (tx_en) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!tx_en) begin
                    if (idx_q == 4'd14) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = '0;
                        load    = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // tx_byte only changes on LOAD entry, keeping it stable while the byte is on the line.
        if (load) begin
            case (idx_d)
                4'd0:    byte_d = 8'h54;
                4'd1:    byte_d = 8'h3D;
                4'd2:    byte_d = nib_chr[0];
                4'd3:    byte_d = nib_chr[1];
                4'd4:    byte_d = nib_chr[2];
                4'd5:    byte_d = nib_chr[3];
                4'd6:    byte_d = 8'h20;
                4'd7:    byte_d = 8'h48;
                4'd8:    byte_d = 8'h3D;
                4'd9:    byte_d = nib_chr[4];
                4'd10:   byte_d = nib_chr[5];
                4'd11:   byte_d = nib_chr[6];
                4'd12:   byte_d = nib_chr[7];
                4'd13:   byte_d = 8'h0D;
                default: byte_d = 8'h0A;
            endcase
        end
    end

    assign drop_d = (data_valid && state_q != S_IDLE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            temp_q  <= 16'h0000;
            humi_q  <= 16'h0000;
            byte_q  <= 8'h00;
            drop_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
            humi_q  <= humi_d;
            byte_q  <= byte_d;
            drop_q  <= drop_d;
        end
    end

    assign tx_byte    = byte_q;
    assign tx_req     = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign err        = (state_q == S_ABORT);
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_sht21_uart_fmt.sv
// Directed bench for sht21_uart_fmt: a behavioural UART TX model collects the
// launched bytes, which are compared against hand-computed frames.
`timescale 1ns/1ps
module tb_sht21_uart_fmt;
    localparam int REQ_HOLD    = 4;
    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] temp_raw = 16'h0000;
    logic [15:0] humi_raw = 16'h0000;
    logic        data_valid = 1'b0;
    logic        tx_en = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_req;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic [7:0]  drop_cnt;

    always #20 clk = ~clk;

    sht21_uart_fmt #(.REQ_HOLD(REQ_HOLD), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .temp_raw   (temp_raw),
        .humi_raw   (humi_raw),
        .data_valid (data_valid),
        .tx_en      (tx_en),
        .tx_byte    (tx_byte),
        .tx_req     (tx_req),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .drop_cnt   (drop_cnt)
    );

    typedef struct {
        logic [15:0]       temp;
        logic [15:0]       humi;
        logic [0:14][7:0]  bytes;
    } vec_t;

    vec_t       vecs [4];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] got [$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         stab_err = 0;
    bit         model_en = 1'b1;
    int         tx_len = 10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART TX model plus monitor: one process so monitor samples precede model updates.
    initial begin
        logic       prev_req, prev_en, inflight, cur_en;
        logic [7:0] lb;
        int         dly, on;
        prev_req = 1'b0; prev_en = 1'b0; inflight = 1'b0; lb = 8'h00; dly = 0; on = 0;
        forever begin
            @(negedge clk);
            cur_en = tx_en;
            if (rst) begin
                inflight = 1'b0;
            end else begin
                if (prev_en && !cur_en) inflight = 1'b0;
                if (tx_req && !prev_req) begin
                    inflight = 1'b1;
                    lb = tx_byte;
                end else if (inflight && tx_byte !== lb) begin
                    stab_err++;
                end
            end
            if (frame_done) done_cnt++;
            if (err) err_cnt++;
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    tx_en = 1'b1;
                    on = tx_len;
                end
            end else if (on > 0) begin
                on--;
                if (on == 0) tx_en = 1'b0;
            end
            if (prev_req && !tx_req && model_en && !rst) begin
                got.push_back(tx_byte);
                dly = 3;
            end
            prev_req = tx_req;
            prev_en  = cur_en;
        end
    end

    task automatic start_frame(input logic [15:0] t, input logic [15:0] h);
        @(negedge clk);
        temp_raw = t;
        humi_raw = h;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input vec_t v, input int d0, input int e0);
        for (int c = 0; c < 8000 && done_cnt == d0 && err_cnt == e0; c++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check({tag, " frame_done pulses"}, done_cnt, d0 + 1);
        check({tag, " err pulses"}, err_cnt, e0);
        check({tag, " busy after frame"}, busy, 1'b0);
        check({tag, " byte count"}, got.size(), 15);
        for (int i = 0; i < 15; i++)
            check($sformatf("%s byte%0d", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF, v.bytes[i]);
        check({tag, " tx_byte stability"}, stab_err, 0);
        $display("frame %s temp=%h humi=%h bytes=%0d", tag, v.temp, v.humi, got.size());
    endtask

    task automatic run_frame(input int vi);
        int d0, e0;
        string tag;
        tag = $sformatf("vec%0d", vi);
        d0 = done_cnt;
        e0 = err_cnt;
        got.delete();
        start_frame(vecs[vi].temp, vecs[vi].humi);
        check({tag, " busy at t+1"}, busy, 1'b1);
        check({tag, " tx_byte at t+1"}, tx_byte, 8'h54);
        check({tag, " tx_req at t+1"}, tx_req, 1'b1);
        for (int k = 2; k <= REQ_HOLD; k++) begin
            @(negedge clk);
            check($sformatf("%s tx_req hold t+%0d", tag, k), tx_req, 1'b1);
        end
        @(negedge clk);
        check({tag, " tx_req fall"}, tx_req, 1'b0);
        finish_frame(tag, vecs[vi], d0, e0);
    endtask

    initial begin
        int d0, e0, fall_c, err_c, err_hi;

        vecs[0].temp = 16'h6A3C; vecs[0].humi = 16'h8F10;
        vecs[0].bytes = {8'h54, 8'h3D, 8'h36, 8'h41, 8'h33, 8'h43, 8'h20, 8'h48,
                         8'h3D, 8'h38, 8'h46, 8'h31, 8'h30, 8'h0D, 8'h0A};
        vecs[1].temp = 16'hFFFF; vecs[1].humi = 16'h0000;
        vecs[1].bytes = {8'h54, 8'h3D, 8'h46, 8'h46, 8'h46, 8'h46, 8'h20, 8'h48,
                         8'h3D, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        vecs[2].temp = 16'h09A0; vecs[2].humi = 16'h1B2C;
        vecs[2].bytes = {8'h54, 8'h3D, 8'h30, 8'h39, 8'h41, 8'h30, 8'h20, 8'h48,
                         8'h3D, 8'h31, 8'h42, 8'h32, 8'h43, 8'h0D, 8'h0A};
        vecs[3].temp = 16'h1234; vecs[3].humi = 16'h5678;
        vecs[3].bytes = {8'h54, 8'h3D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h20, 8'h48,
                         8'h3D, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx_byte", tx_byte, 8'h00);
        check("reset tx_req", tx_req, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        check("reset err", err, 1'b0);
        check("reset drop_cnt", drop_cnt, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", busy, 1'b0);

        for (int i = 0; i < 3; i++) run_frame(i);

        // Capture during a frame is dropped; long data_valid burst saturates the counter
        tx_len = 40;
        d0 = done_cnt; e0 = err_cnt; got.delete();
        start_frame(vecs[3].temp, vecs[3].humi);
        for (int c = 0; c < 2000 && got.size() < 5; c++) @(negedge clk);
        temp_raw = 16'hDEAD; humi_raw = 16'hBEEF; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        check("drop single", drop_cnt, 8'd1);
        data_valid = 1'b1;
        repeat (100) @(negedge clk);
        check("drop 101", drop_cnt, 8'd101);
        repeat (200) @(negedge clk);
        check("drop saturate", drop_cnt, 8'd255);
        check("busy during burst", busy, 1'b1);
        data_valid = 1'b0;
        finish_frame("drop", vecs[3], d0, e0);
        tx_len = 10;

        // Handshake timeout: transmitter never answers
        model_en = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        fall_c = -1; err_c = -1; err_hi = 0;
        start_frame(16'h0000, 16'h0000);
        for (int c = 0; c < 80; c++) begin
            if (fall_c < 0 && !tx_req) fall_c = c;
            if (err) begin
                err_hi++;
                if (err_c < 0) err_c = c;
            end
            @(negedge clk);
        end
        check("timeout req fall", fall_c, REQ_HOLD);
        check("timeout err delay", err_c - fall_c, ACK_TIMEOUT);
        check("timeout err width", err_hi, 1);
        check("timeout busy", busy, 1'b0);
        check("timeout no frame_done", done_cnt, d0);
        check("timeout drop hold", drop_cnt, 8'd255);
        $display("frame timeout err_delay=%0d", err_c - fall_c);
        model_en = 1'b1;

        // Reset during byte 8
        e0 = err_cnt; got.delete();
        start_frame(vecs[0].temp, vecs[0].humi);
        for (int c = 0; c < 2000 && got.size() < 9; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst tx_byte", tx_byte, 8'h00);
        check("midrst tx_req", tx_req, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst frame_done", frame_done, 1'b0);
        check("midrst err", err, 1'b0);
        check("midrst drop_cnt", drop_cnt, 8'h00);
        rst = 1'b0;
        for (int c = 0; c < 200 && tx_en; c++) @(negedge clk);
        @(negedge clk);
        check("midrst no err pulse", err_cnt, e0);
        $display("frame midrst aborted after %0d bytes", got.size());
        run_frame(0);

        // data_valid in DONE is dropped, data_valid the cycle after is captured
        d0 = done_cnt; e0 = err_cnt; got.delete();
        start_frame(vecs[2].temp, vecs[2].humi);
        for (int c = 0; c < 3000 && !frame_done; c++) @(negedge clk);
        check("done seen", frame_done, 1'b1);
        temp_raw = vecs[1].temp; humi_raw = vecs[1].humi; data_valid = 1'b1;
        @(negedge clk);
        check("drop at done", drop_cnt, 8'd1);
        check("idle after done", busy, 1'b0);
        check("prior frame bytes", got.size(), 15);
        got.delete();
        d0 = done_cnt;
        @(negedge clk);
        data_valid = 1'b0;
        check("capture after done busy", busy, 1'b1);
        check("capture after done byte", tx_byte, 8'h54);
        finish_frame("after_done", vecs[1], d0, e0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
